// File: rtl/load_store_unit_if.sv
// Core-side request/status and memory-bus signals of the load/store unit.
// master = the LSU itself; slave = the core/memory environment around it.
interface load_store_unit_if;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    input  start, is_store, funct3, address, store_data, mem_ready, mem_rdata,
    output busy, done, fault, load_data, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output start, is_store, funct3, address, store_data, mem_ready, mem_rdata,
    input  busy, done, fault, load_data, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one load or store per start over a ready-handshake bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of force-aligning them.
module load_store_unit (
  input  logic              clk_i,
  input  logic              rst_i,
  load_store_unit_if.master lsu_io
);
  // state | meaning
  // IDLE  | waiting for start
  // REQ   | bus request outstanding, waiting for mem_ready
  // DONE  | one-cycle completion pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic        fault_q, fault_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_data_q, load_data_d;

  logic        legal;
  logic        start_fault;
  logic [1:0]  off_eff;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        in_req;

  always_comb begin
    legal = 1'b0;
    case (lsu_io.funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !lsu_io.is_store;
      default:                legal = 1'b0;
    endcase
  end

  // Halfword/word offsets are forced aligned; with trapping on, misaligned ones never reach the bus.
  always_comb begin
    off_eff = lsu_io.address[1:0];
    if (lsu_io.funct3[1:0] == 2'b01)
      off_eff[0] = 1'b0;
    else if (lsu_io.funct3[1:0] == 2'b10)
      off_eff = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((lsu_io.funct3[1:0] == 2'b01) && lsu_io.address[0]) ||
                      ((lsu_io.funct3[1:0] == 2'b10) && (lsu_io.address[1:0] != 2'b00));
  assign start_fault = !legal || misaligned;
`else
  assign start_fault = !legal;
`endif

  always_comb begin
    st_wdata = lsu_io.store_data;
    st_wstrb = 4'b1111;
    case (lsu_io.funct3[1:0])
      2'b00: begin
        st_wdata = {4{lsu_io.store_data[7:0]}};
        st_wstrb = 4'b0001 << off_eff;
      end
      2'b01: begin
        st_wdata = {2{lsu_io.store_data[15:0]}};
        st_wstrb = off_eff[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = lsu_io.mem_rdata[7:0];
      2'd1:    ld_byte = lsu_io.mem_rdata[15:8];
      2'd2:    ld_byte = lsu_io.mem_rdata[23:16];
      default: ld_byte = lsu_io.mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? lsu_io.mem_rdata[31:16] : lsu_io.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = lsu_io.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    we_d        = we_q;
    fault_d     = fault_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_io.start) begin
          addr_d   = {lsu_io.address[31:2], 2'b00};
          we_d     = lsu_io.is_store;
          wdata_d  = lsu_io.is_store ? st_wdata : 32'd0;
          wstrb_d  = lsu_io.is_store ? st_wstrb : 4'd0;
          funct3_d = lsu_io.funct3;
          off_d    = off_eff;
          fault_d  = start_fault;
          state_d  = start_fault ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (lsu_io.mem_ready) begin
          if (!we_q)
            load_data_d = ld_ext;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      we_q        <= we_d;
      fault_q     <= fault_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
    end
  end

  // Bus outputs come straight from state, so an async reset drops them at once.
  assign in_req           = (state_q == S_REQ);
  assign lsu_io.mem_req   = in_req;
  assign lsu_io.mem_we    = in_req & we_q;
  assign lsu_io.mem_addr  = in_req ? addr_q : 32'd0;
  assign lsu_io.mem_wdata = in_req ? wdata_q : 32'd0;
  assign lsu_io.mem_wstrb = in_req ? wstrb_q : 4'd0;
  assign lsu_io.busy      = (state_q != S_IDLE);
  assign lsu_io.done      = (state_q == S_DONE);
  assign lsu_io.fault     = (state_q == S_DONE) & fault_q;
  assign lsu_io.load_data = load_data_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage sitting directly downstream of the ALU in the RISC-V core: it consumes the ALU's 32-bit add result as an effective address and performs one RV32I load or store over a simple ready-handshake data bus. Handles byte-lane selection, store-data replication, load sign/zero extension and alignment checking. It signals completion to the writeback stage with a single-cycle `done` pulse.

## Interface
- No parameters. Data and address widths are fixed at 32 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request an access; sampled only while `busy`=0.
- `is_store` input 1: 1 selects store, 0 selects load. Sampled with `start`.
- `funct3` input 3: RV32I width/sign field. Sampled with `start`.
- `address` input 32: effective address, taken from the ALU result. Sampled with `start`.
- `store_data` input 32: rs2 value. Sampled with `start`.
- `busy` output 1: access in progress.
- `done` output 1: one-cycle completion pulse.
- `fault` output 1: valid only in the `done` cycle; the access was rejected.
- `load_data` output 32: extended load result. Holds its value until the next successful load.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write enable.
- `mem_addr` output 32: bus address, word-aligned (bits [1:0] = 0).
- `mem_wdata` output 32: bus write data.
- `mem_wstrb` output 4: bus byte strobes; bit n enables byte lane n.
- `mem_ready` input 1: slave accepts the write or returns read data in this cycle.
- `mem_rdata` input 32: read data, valid when `mem_ready`=1.

## Operation
- FSM states:
  - IDLE
    - `start`=1 with an aligned, legal access goes to REQ.
    - `start`=1 with a misaligned or illegal access goes to DONE with `fault` set.
  - REQ
    - On `mem_ready`=1: capture read data if the access is a load, then go to DONE.
    - Otherwise stay in REQ.
  - DONE: always returns to IDLE.
- `busy`=1 in REQ and DONE. `done`=1 only in DONE.
- `start` is ignored while `busy`=1.
- Supported `funct3` encodings:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Any other encoding is illegal and always faults, independent of configuration. A faulting access never asserts `mem_req`.
- Store lane rules:
  - Byte store: `store_data[7:0]` replicated to all four lanes; `mem_wstrb` = 1 shifted left by `address[1:0]`.
  - Halfword store: `store_data[15:0]` replicated to both halves; `mem_wstrb` = 0011 when `address[1]`=0, 1100 when `address[1]`=1.
  - Word store: `mem_wstrb` = 1111.
- Load extraction:
  - The byte or halfword lane is selected by `address[1:0]`.
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
  - Loads drive `mem_wstrb`=0000 and `mem_we`=0.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are registered at `start` and held stable for the whole of REQ.
- Outside REQ, these bus outputs are held at 0.

## Timing
- Reset values: all outputs 0; FSM in IDLE.
- Reset asserted mid-access drops `mem_req` immediately, without waiting for a clock edge. The pending access is abandoned with no `done`, and `load_data` clears to 0.
- Cycle accounting:
  - `start` is sampled at edge 0.
  - `mem_req`=1 from edge 0 until the edge at which `mem_ready`=1 is sampled.
  - `done`=1 for the following cycle.
- Minimum latency: `done` is high 2 cycles after `start` (zero-wait-state bus).
- Each wait cycle with `mem_ready`=0 adds one cycle of latency.
- Faulting access: `done`=1 and `fault`=1 in the cycle after `start`.
- `load_data` updates on the same edge at which DONE is entered; it is valid during the `done` cycle and afterward.
- A new `start` is accepted in the cycle after `done`, when the FSM is back in IDLE.
- `start` high in the same cycle as `done` is ignored.
- `mem_ready` asserted outside REQ is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword access with `address[0]`=1 faults.
  - A word access with `address[1:0]`≠00 faults.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No alignment fault is raised.
  - Halfword accesses are performed as if `address[0]`=0.
  - Word accesses are performed as if `address[1:0]`=00.
  - `fault` is raised only for illegal `funct3` encodings.

## Test plan
- LW, `address`=0x100, `mem_ready` tied high, `mem_rdata`=0xDEADBEEF:
  - `mem_req` high for exactly 1 cycle with `mem_addr`=0x100.
  - `done` high 2 cycles after `start`.
  - `load_data`=0xDEADBEEF, `fault`=0.
- LB then LBU, `address`=0x203, `mem_rdata`=0x80FF1234:
  - LB gives `load_data`=0xFFFFFF80.
  - LBU gives `load_data`=0x00000080.
- SB, `address`=0x102, `store_data`=0x000000AB, `mem_ready` delayed 3 cycles:
  - `mem_we`=1, `mem_wstrb`=0100, `mem_wdata`=0xABABABAB, `mem_addr`=0x100.
  - Bus outputs held stable for 4 cycles; `done` appears 5 cycles after `start`.
- SH at `address`=0x101 with the macro defined:
  - `mem_req` is never asserted.
  - `done`=1 and `fault`=1 in the cycle after `start`.
- Same SH with the macro undefined:
  - `mem_addr`=0x100, `mem_wstrb`=0011, `fault`=0.
- `funct3`=011 load: fault pulse with no bus request. Separately, assert `reset` during REQ:
  - `mem_req` and `busy` fall immediately.
  - No `done` pulse follows.
